// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - CPU-to-memory bridge: word-aligned access, lane steering, load extension, error detection
// Optional memory-wait timeout is enabled by defining MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [2:0]  cpu_funct3,
   output logic [31:0] cpu_rdata,
   output logic        cpu_resp,
   output logic        cpu_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byte_enable,
   input  logic        mem_resp,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [2:0]  funct3_q;
   logic [3:0]  be_q;
   logic        write_q, err_q;

   logic        req, illegal, timeout;
   logic [3:0]  be_new;
   logic [31:0] wdata_rep, load_ext;
   logic [7:0]  load_byte;
   logic [15:0] load_half;

   assign req = cpu_read | cpu_write;

   always_comb begin
      illegal = 1'b0;
      if (cpu_read && cpu_write)                                     illegal = 1'b1;
      if (cpu_read && (cpu_funct3 == 3'd3 || cpu_funct3[2:1] == 2'b11)) illegal = 1'b1;
      if (cpu_write && cpu_funct3 > 3'd2)                            illegal = 1'b1;
      if (cpu_funct3[1:0] == 2'd2 && cpu_addr[1:0] != 2'b00)         illegal = 1'b1;
      if (cpu_funct3[1:0] == 2'd1 && cpu_addr[0])                    illegal = 1'b1;
   end

   // Reads always fetch the whole word; only stores narrow the lane enables.
   always_comb begin
      be_new    = 4'b1111;
      wdata_rep = cpu_wdata;
      case (cpu_funct3[1:0])
         2'd0: begin
            wdata_rep = {4{cpu_wdata[7:0]}};
            if (cpu_write) be_new = 4'b0001 << cpu_addr[1:0];
         end
         2'd1: begin
            wdata_rep = {2{cpu_wdata[15:0]}};
            if (cpu_write) be_new = 4'b0011 << cpu_addr[1:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      load_byte = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
      load_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'd0:    load_ext = {{24{load_byte[7]}}, load_byte};
         3'd1:    load_ext = {{16{load_half[15]}}, load_half};
         3'd4:    load_ext = {24'h0, load_byte};
         3'd5:    load_ext = {16'h0, load_half};
         default: load_ext = mem_rdata;
      endcase
   end

`ifdef MEM_BRIDGE_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     cnt_q <= '0;
      else if (state_q != ISSUE)    cnt_q <= '0;
      else if (!mem_resp)           cnt_q <= cnt_q + 1'b1;
   end

   // A response in the limit cycle still counts as a normal completion.
   assign timeout = (state_q == ISSUE) && !mem_resp &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic cfg_unused;
   assign cfg_unused = (CNT_W > 0) && (TIMEOUT_CYCLES > 0);
   assign timeout    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = illegal ? DONE : ISSUE;
         ISSUE:   if (mem_resp || timeout) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_read  = (state_q == ISSUE) && !write_q;
      mem_write = (state_q == ISSUE) && write_q;
      cpu_resp  = (state_q == DONE);
      cpu_err   = (state_q == DONE) && err_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         funct3_q <= '0;
         be_q     <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req) begin
               addr_q   <= cpu_addr;
               wdata_q  <= wdata_rep;
               funct3_q <= cpu_funct3;
               be_q     <= be_new;
               write_q  <= cpu_write;
               err_q    <= illegal;
               if (illegal) rdata_q <= '0;
            end
            ISSUE: if (mem_resp) begin
               err_q <= 1'b0;
               if (!write_q) rdata_q <= load_ext;
            end else if (timeout) begin
               err_q   <= 1'b1;
               rdata_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign mem_address     = {addr_q[31:2], 2'b00};
   assign mem_wdata       = wdata_q;
   assign mem_byte_enable = be_q;
   assign cpu_rdata       = rdata_q;

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits between the multicycle control/datapath (CPU side) and the physical memory port (memory side).
- Accepts level-held read/write requests and a byte address, and issues one word-aligned memory transaction per request.
- Generates byte enables and replicated write data, aligns and sign/zero-extends load data, and returns a one-cycle cpu_resp.
- Detects misaligned or illegal accesses and completes them without touching memory.

Parameters:
- TIMEOUT_CYCLES, 255: memory-wait limit in cycles. Used only when MEM_BRIDGE_TIMEOUT_EN is defined.
- CNT_W, 8: timeout counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- cpu_read  input  1  load/fetch request, held until cpu_resp.
- cpu_write  input  1  store request, held until cpu_resp.
- cpu_addr  input  32  byte address (MAR).
- cpu_wdata  input  32  store data, value in low bits.
- cpu_funct3  input  3  width code: 0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu.
- cpu_rdata  output  32  aligned, extended load result; held until the next transaction completes.
- cpu_resp  output  1  completion pulse, exactly one cycle.
- cpu_err  output  1  valid with cpu_resp: misaligned, illegal, or timeout.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_address  output  32  word address, {cpu_addr[31:2],2'b00}.
- mem_wdata  output  32  replicated store data.
- mem_byte_enable  output  4  lane enables; 4'b1111 on reads.
- mem_resp  input  1  memory completion.
- mem_rdata  input  32  memory read word, valid with mem_resp.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - cpu_rdata, cpu_resp, cpu_err, mem_read, mem_write, mem_address, mem_wdata and mem_byte_enable all 0.
  - Memory strobes drop in the same cycle reset is asserted.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - Ignores mem_resp.
  - On cpu_read|cpu_write, latches addr, wdata, funct3 and direction.
  - If the access is legal, next state is ISSUE; otherwise next state is DONE with err=1.
- Illegal-access rules:
  - cpu_read and cpu_write both high.
  - Load funct3 in {3,6,7}.
  - Store funct3 >2.
  - Word access with addr[1:0]!=0.
  - Half access with addr[0]!=0.
- ISSUE:
  - mem_read or mem_write is driven from registered state, and is held steady along with address, wdata and byte_enable.
  - On mem_resp: capture the extended load data into cpu_rdata (reads only), then go to DONE with err=0.
- DONE:
  - cpu_resp=1 for one cycle; cpu_err is set per the outcome.
  - Next state is IDLE.
  - On err, cpu_rdata=0.
  - Store completion leaves cpu_rdata unchanged.
- Latency: the request is first seen at edge k, and ISSUE is occupied from k+1. mem_resp in ISSUE cycle j gives cpu_resp in cycle j+1. Minimum is 2 cycles from request to cpu_resp. A misaligned access gives cpu_resp in the cycle after the request is accepted.
- Back-to-back: a request still high in the cycle after DONE starts a new transaction. The control drops its request after cpu_resp, so none is duplicated.
- Byte enables:
  - sb: 4'b0001<<addr[1:0].
  - sh: 4'b0011<<addr[1:0].
  - sw: 4'b1111.
- Write data:
  - sb: {4{wdata[7:0]}}.
  - sh: {2{wdata[15:0]}}.
  - sw: wdata.
- Load extraction:
  - Byte = mem_rdata[8*addr[1:0]+:8]; half = mem_rdata[16*addr[1]+:16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- mem_resp arriving outside ISSUE is ignored.
- Reset mid-ISSUE aborts the transaction; no cpu_resp is produced.

Optional Feature:
- MEM_BRIDGE_TIMEOUT_EN defined:
  - Counter clears on ISSUE entry and increments each ISSUE cycle without mem_resp.
  - When the count reaches TIMEOUT_CYCLES, strobes drop and the FSM goes to DONE with cpu_err=1 and cpu_rdata=0.
  - mem_resp in the same cycle as the limit wins; this is a normal completion.
- Undefined: no counter is built, and ISSUE waits indefinitely for mem_resp.

Test Plan:
- lw addr 0x100, mem_resp 3 cycles after ISSUE entry, mem_rdata 0xDEADBEEF -> mem_address 0x100, mem_read high 3 cycles; cpu_resp one cycle later, cpu_rdata 0xDEADBEEF, cpu_err 0.
- lb addr 0x103, mem_rdata 0x80FF1234 -> cpu_rdata 0xFFFFFF80. Repeat with lbu -> 0x00000080. lh at 0x102 -> 0xFFFF80FF.
- sh addr 0x202, wdata 0x0000ABCD -> mem_address 0x200, mem_byte_enable 4'b1100, mem_wdata 0xABCDABCD, mem_write until mem_resp; cpu_resp, cpu_rdata unchanged.
- lw addr 0x101 -> mem_read never asserted; cpu_resp=1 and cpu_err=1 in the second cycle, cpu_rdata 0. Same for sh at 0x201 and for read+write together.
- rst=0 during ISSUE -> mem_read 0 immediately. mem_resp pulsed after reset release -> no cpu_resp; state IDLE.
- MEM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, no mem_resp -> mem_read high 4 cycles, then cpu_resp with cpu_err=1, cpu_rdata 0.
